fx_mac_accum: RTL and testbench

//  Parametrised signed fixed-point multiply-accumulate engine, Q(DATA_W-FRAC_W).FRAC_W.

---
 rtl/fx_mac_accum.sv | 122 ++++++++++++
 tb/tb_fx_mac_accum.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fx_mac_accum.sv
// Signed fixed-point multiply-accumulate engine: accepts a burst of operand pairs and emits
// one rounded, symmetrically saturated result per burst.
module fx_mac_accum #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 9,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CNT_W-1:0]         len,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     sat_flag,
  output logic                     busy,
  output logic [1:0]               state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DRAIN  = 2'd2,
    RESULT = 2'd3
  } state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-2){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0]       OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0]       OUT_MIN = {1'b1, {(DATA_W-2){1'b0}}, 1'b1};
  localparam logic signed [ACC_W:0]   R_MAX   = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0]   R_MIN   = -R_MAX;
  localparam logic signed [ACC_W:0]   R_HALF  = (ACC_W+1)'(1) << (FRAC_W-1);

  state_t                     state;
  logic [CNT_W-1:0]           len_q;
  logic [CNT_W-1:0]           cnt;
  logic [CNT_W-1:0]           cnt_nxt;
  logic signed [2*DATA_W-1:0] prod;
  logic                       prod_vld;
  logic signed [ACC_W-1:0]    acc;
  logic                       hs;
  logic signed [ACC_W:0]      sum;
  logic                       acc_ovf;
  logic signed [ACC_W:0]      rnd_sum;
  logic signed [ACC_W:0]      rnd;
  logic                       out_hi;
  logic                       out_lo;

  assign in_ready = (state == ACCUM);
  assign busy     = (state != IDLE);
  assign state_o  = state;
  assign hs       = in_valid & in_ready;
  assign cnt_nxt  = cnt + CNT_W'(1);

  // One guard bit above the accumulator detects overflow of acc + P as a sign mismatch.
  always_comb begin
    sum     = {acc[ACC_W-1], acc} + {{(ACC_W+1-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    acc_ovf = sum[ACC_W] ^ sum[ACC_W-1];
    rnd_sum = {acc[ACC_W-1], acc} + R_HALF;
    rnd     = rnd_sum >>> FRAC_W;
    out_hi  = (rnd > R_MAX);
    out_lo  = (rnd < R_MIN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      len_q     <= '0;
      cnt       <= '0;
      prod      <= '0;
      prod_vld  <= 1'b0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      sat_flag  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      prod_vld  <= hs;
      if (hs) prod <= (2*DATA_W)'(a) * (2*DATA_W)'(b);

      // Bubbles (prod_vld=0) leave acc untouched, so stalls on in_valid are harmless.
      if (prod_vld) begin
        if (acc_ovf) begin
          acc      <= sum[ACC_W] ? ACC_MIN : ACC_MAX;
          sat_flag <= 1'b1;
        end else begin
          acc <= sum[ACC_W-1:0];
        end
      end

      case (state)
        IDLE: if (start) begin
          len_q    <= len;
          cnt      <= '0;
          acc      <= '0;
          sat_flag <= 1'b0;
          state    <= (len != '0) ? ACCUM : DRAIN;
        end
        ACCUM: if (hs) begin
          cnt <= cnt_nxt;
          if (cnt_nxt == len_q) state <= DRAIN;
        end
        DRAIN: if (!prod_vld) state <= RESULT;
        RESULT: begin
          if (out_hi)      out_data <= OUT_MAX;
          else if (out_lo) out_data <= OUT_MIN;
          else             out_data <= rnd[DATA_W-1:0];
          if (out_hi || out_lo) sat_flag <= 1'b1;
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fx_mac_accum.sv
// Directed bench for fx_mac_accum: stimulus pushes hand-computed results to a queue,
// a monitor pops and compares on every out_valid.
module tb_fx_mac_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic [15:0] out_data;
  logic        sat_flag;
  logic        busy;
  logic [1:0]  state_o;

  fx_mac_accum #(.DATA_W(16), .FRAC_W(9), .ACC_W(40), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_data(out_data), .sat_flag(sat_flag),
    .busy(busy), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    logic        sat;
    int          at;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          seen  = 0;
  logic [15:0] va[8];
  logic [15:0] vb[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out_valid: got out_data %0h with nothing expected (cycle %0d)",
                   out_data, cyc);
        end else begin
          e = sb.pop_front();
          check("out_data", {16'h0, out_data}, {16'h0, e.data});
          check("sat_flag", {31'h0, sat_flag}, {31'h0, e.sat});
          check("latency", cyc, e.at);
        end
        seen++;
      end
    end
  end

  // n terms from va/vb; gap inserts an idle cycle between terms; poke re-pulses start mid-burst.
  task automatic burst(input int n, input bit gap, input bit poke,
                       input logic [15:0] ed, input logic es);
    int   s_cyc;
    int   hs_cyc;
    int   goal;
    exp_t e;
    goal = seen + 1;
    @(posedge clk); #1;
    start = 1'b1;
    len   = n[7:0];
    s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    len   = 8'd3;
    hs_cyc = s_cyc;
    for (int i = 0; i < n; i++) begin
      if (gap && i > 0) begin
        in_valid = 1'b0;
        a = 16'h7FFF;
        b = 16'h7FFF;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      a = va[i];
      b = vb[i];
      if (poke && i == 0) begin
        start = 1'b1;
        len   = 8'd5;
      end
      @(negedge clk);
      check("in_ready_accum", {31'h0, in_ready}, 32'h1);
      hs_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
    end
    e.data = ed;
    e.sat  = es;
    e.at   = (n == 0) ? s_cyc + 3 : hs_cyc + 4;
    sb.push_back(e);
    in_valid = 1'b1;
    a = 16'h7FFF;
    b = 16'h7FFF;
    if (n > 0) begin
      @(negedge clk);
      check("in_ready_drain", {31'h0, in_ready}, 32'h0);
      check("state_drain", {30'h0, state_o}, 32'h2);
    end
    for (int k = 0; k < 20 && seen < goal; k++) @(posedge clk);
    if (seen < goal) begin
      tests++;
      fails++;
      $display("FAIL timeout: got no out_valid, expected one within 20 cycles (cycle %0d)", cyc);
      sb.delete();
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  {31'h0, in_ready},  32'h0);
    check({tag, "_out_valid"}, {31'h0, out_valid}, 32'h0);
    check({tag, "_out_data"},  {16'h0, out_data},  32'h0);
    check({tag, "_sat_flag"},  {31'h0, sat_flag},  32'h0);
    check({tag, "_busy"},      {31'h0, busy},      32'h0);
    check({tag, "_state"},     {30'h0, state_o},   32'h0);
  endtask

  initial begin : stim
    rst = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; a = '0; b = '0;
    #1;
    check_reset_outputs("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // 4.5 * -0.75 = -3.375
    va[0] = 16'h0900; vb[0] = 16'hFE80;
    burst(1, 1'b0, 1'b0, 16'hF940, 1'b0);

    for (int i = 0; i < 4; i++) begin va[i] = 16'h0200; vb[i] = 16'h0200; end
    burst(4, 1'b1, 1'b0, 16'h0800, 1'b0);

    // exactly half an LSB rounds up; just under half rounds down
    va[0] = 16'h0001; vb[0] = 16'h0100;
    burst(1, 1'b0, 1'b0, 16'h0001, 1'b0);
    va[0] = 16'h0001; vb[0] = 16'h00FF;
    burst(1, 1'b0, 1'b0, 16'h0000, 1'b0);

    va[0] = 16'h0200; vb[0] = 16'h0200;
    burst(1, 1'b0, 1'b0, 16'h0200, 1'b0);
    burst(0, 1'b0, 1'b0, 16'h0000, 1'b0);
    burst(1, 1'b0, 1'b1, 16'h0200, 1'b0);

    va[0] = 16'h7FFF; vb[0] = 16'h7FFF;
    burst(1, 1'b0, 1'b0, 16'h7FFF, 1'b1);
    va[0] = 16'h8001; vb[0] = 16'h7FFF;
    burst(1, 1'b0, 1'b0, 16'h8001, 1'b1);

    // abort a 5-term burst after 2 accepted terms
    @(posedge clk); #1;
    start = 1'b1; len = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1; a = 16'h0200; b = 16'h0200;
    @(posedge clk); @(posedge clk); #1;
    check("pre_abort_busy", {31'h0, busy}, 32'h1);
    rst = 1'b0;
    #1;
    check_reset_outputs("abort");
    in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    repeat (6) @(posedge clk);

    va[0] = 16'h0900; vb[0] = 16'hFE80;
    burst(1, 1'b0, 1'b0, 16'hF940, 1'b0);

    repeat (5) @(posedge clk);
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL leftover: got %0d pending results, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
